// File: rtl/ldpc_iter_ctrl.sv
// LDPC iteration controller: sequences CNU and PE phases,
// accumulates the frame syndrome and decides when to stop.
module ldpc_iter_ctrl #(
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 6,
  parameter int MAX_ITER = 8,
  parameter int CNU_LAT  = 1,
  parameter int ITER_W   = 4,
  parameter int RA_W     = 2,
  parameter int CA_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              p_bit,
  output logic              busy,
  output logic              cnu_en,
  output logic [RA_W-1:0]   row_addr,
  output logic              pe_en,
  output logic [CA_W-1:0]   col_addr,
  output logic [ITER_W-1:0] iter_count,
  output logic              done,
  output logic              converged
);

  localparam int DW = (CNU_LAT > 1) ? $clog2(CNU_LAT) : 1;

  localparam logic [RA_W-1:0] ROW_LAST =
    RA_W'(NUM_ROWS - 1);
  localparam logic [CA_W-1:0] COL_LAST =
    CA_W'(NUM_COLS - 1);
  localparam logic [DW-1:0] DRAIN_LAST =
    DW'(CNU_LAT - 1);
  localparam logic [ITER_W-1:0] ITER_LAST =
    ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CN,
    S_DRAIN,
    S_CHECK,
    S_VN,
    S_DONE
  } state_t;

  state_t             state;
  logic [CNU_LAT-1:0] vld_sr;
  logic [DW-1:0]      drain_cnt;
  logic               syndrome;
  logic [ITER_W-1:0]  iter_inc;
  logic               vld_out;

  // Next iteration count and the aligned p_bit valid flag
  always_comb begin
    iter_inc = iter_count + ITER_W'(1);
    vld_out  = vld_sr[CNU_LAT-1];
  end

  // Phase sequencer, syndrome capture and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      vld_sr     <= '0;
      drain_cnt  <= '0;
      syndrome   <= 1'b0;
      busy       <= 1'b0;
      cnu_en     <= 1'b0;
      row_addr   <= '0;
      pe_en      <= 1'b0;
      col_addr   <= '0;
      iter_count <= '0;
      done       <= 1'b0;
      converged  <= 1'b0;
    end else begin
      vld_sr <= (vld_sr << 1) | CNU_LAT'(cnu_en);
      if (vld_out)
        syndrome <= syndrome | p_bit;
      done <= 1'b0;

      if (abort && state != S_IDLE) begin
        state     <= S_IDLE;
        busy      <= 1'b0;
        cnu_en    <= 1'b0;
        row_addr  <= '0;
        pe_en     <= 1'b0;
        col_addr  <= '0;
        converged <= 1'b0;
        vld_sr    <= '0;
        syndrome  <= 1'b0;
        drain_cnt <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start && !abort) begin
              state      <= S_CN;
              busy       <= 1'b1;
              cnu_en     <= 1'b1;
              row_addr   <= '0;
              iter_count <= '0;
              converged  <= 1'b0;
              syndrome   <= 1'b0;
              vld_sr     <= '0;
            end
          end
          S_CN: begin
            if (row_addr == ROW_LAST) begin
              state     <= S_DRAIN;
              cnu_en    <= 1'b0;
              row_addr  <= '0;
              drain_cnt <= '0;
            end else begin
              row_addr <= row_addr + RA_W'(1);
            end
          end
          S_DRAIN: begin
            if (drain_cnt == DRAIN_LAST)
              state <= S_CHECK;
            else
              drain_cnt <= drain_cnt + DW'(1);
          end
          S_CHECK: begin
            if (!syndrome) begin
              state     <= S_DONE;
              done      <= 1'b1;
              converged <= 1'b1;
            end else begin
              state    <= S_VN;
              pe_en    <= 1'b1;
              col_addr <= '0;
              syndrome <= 1'b0;
            end
          end
          S_VN: begin
            if (col_addr == COL_LAST) begin
              pe_en      <= 1'b0;
              col_addr   <= '0;
              iter_count <= iter_inc;
              if (iter_inc == ITER_LAST) begin
                state     <= S_DONE;
                done      <= 1'b1;
                converged <= 1'b0;
              end else begin
                state    <= S_CN;
                cnu_en   <= 1'b1;
                row_addr <= '0;
              end
            end else begin
              col_addr <= col_addr + CA_W'(1);
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Bench for ldpc_iter_ctrl: offset-based decode model with
// per-cycle compare, directed timeline pins and random traffic.
module tb_ldpc_iter_ctrl;

  localparam int NR  = 4;
  localparam int NC  = 6;
  localparam int MI  = 8;
  localparam int LAT = 1;
  localparam int IL  = NR + LAT + 1 + NC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       p_bit = 1'b0;
  logic       busy;
  logic       cnu_en;
  logic [1:0] row_addr;
  logic       pe_en;
  logic [2:0] col_addr;
  logic [3:0] iter_count;
  logic       done;
  logic       converged;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  int pmode = 0;
  int pth = 0;

  // model: mode 0 idle, 1 decoding, 2 done cycle
  int m_mode = 0;
  int m_off = 0;
  int m_iter = 0;
  bit m_conv = 1'b0;
  bit m_synd = 1'b0;

  ldpc_iter_ctrl #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .MAX_ITER(MI),
    .CNU_LAT(LAT), .ITER_W(4), .RA_W(2), .CA_W(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .abort(abort), .p_bit(p_bit), .busy(busy),
    .cnu_en(cnu_en), .row_addr(row_addr),
    .pe_en(pe_en), .col_addr(col_addr),
    .iter_count(iter_count), .done(done),
    .converged(converged)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: position within an iteration decides outputs
  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode <= 0; m_off <= 0; m_iter <= 0;
      m_conv <= 0; m_synd <= 0;
    end else if (m_mode != 0 && abort) begin
      m_mode <= 0; m_off <= 0;
      m_conv <= 0; m_synd <= 0;
    end else begin
      case (m_mode)
        0: if (start && !abort) begin
          m_mode <= 1; m_off <= 0; m_iter <= 0;
          m_conv <= 0; m_synd <= 0;
        end
        1: begin
          if (m_off >= LAT && m_off < LAT + NR)
            m_synd <= m_synd | p_bit;
          if (m_off == NR + LAT) begin
            if (!m_synd) begin
              m_mode <= 2; m_conv <= 1;
            end else begin
              m_synd <= 0; m_off <= m_off + 1;
            end
          end else if (m_off == IL - 1) begin
            m_iter <= m_iter + 1;
            if (m_iter + 1 == MI) begin
              m_mode <= 2; m_conv <= 0;
            end else begin
              m_off <= 0;
            end
          end else begin
            m_off <= m_off + 1;
          end
        end
        default: m_mode <= 0;
      endcase
    end
  end

  // Parity source, chosen per test
  always @(negedge clk) begin
    case (pmode)
      0: p_bit = 1'b0;
      1: p_bit = 1'b1;
      2: p_bit = (m_iter < 2);
      3: p_bit = (m_mode == 1 && m_iter == 0 &&
                  m_off == LAT + NR - 1);
      default: p_bit = ($urandom_range(0, 99) < pth);
    endcase
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (chk_on) begin
      bit ec;
      bit ep;
      ec = (m_mode == 1 && m_off < NR);
      ep = (m_mode == 1 && m_off > NR + LAT);
      chk("busy", busy, m_mode != 0);
      chk("cnu_en", cnu_en, ec);
      chk("row_addr", row_addr, ec ? m_off : 0);
      chk("pe_en", pe_en, ep);
      chk("col_addr", col_addr,
          ep ? m_off - NR - LAT - 1 : 0);
      chk("done", done, m_mode == 2);
      chk("iter_count", iter_count, m_iter);
      chk("converged", converged, m_conv);
    end
  end

  task automatic run_dec(input int pm, input int poke,
                         output int dcyc, output int vnph,
                         output int pecyc, output int c1st,
                         output int ccnt);
    bit prev;
    pmode = pm;
    dcyc = -1; vnph = 0; pecyc = 0;
    c1st = -1; ccnt = 0; prev = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = (k == poke);
      if (cnu_en) begin
        ccnt++;
        if (c1st < 0) c1st = k;
      end
      if (pe_en) pecyc++;
      if (pe_en && !prev) vnph++;
      prev = pe_en;
      if (done) begin
        dcyc = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int dc, vn, pc, cf, cc;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_iter", iter_count, 0);

    // early convergence
    run_dec(0, -1, dc, vn, pc, cf, cc);
    chk("conv0_done_cyc", dc, 7);
    chk("conv0_cnu_first", cf, 1);
    chk("conv0_cnu_cnt", cc, 4);
    chk("conv0_pe_cyc", pc, 0);
    chk("conv0_converged", converged, 1);
    chk("conv0_iter", iter_count, 0);
    @(negedge clk);
    chk("conv0_idle_busy", busy, 0);

    // max iterations
    run_dec(1, -1, dc, vn, pc, cf, cc);
    chk("max_done_cyc", dc, 97);
    chk("max_vn_phases", vn, 8);
    chk("max_pe_cyc", pc, 48);
    chk("max_iter", iter_count, 8);
    chk("max_converged", converged, 0);
    repeat (2) @(negedge clk);

    // convergence in third iteration
    run_dec(2, -1, dc, vn, pc, cf, cc);
    chk("it3_done_cyc", dc, 31);
    chk("it3_vn_phases", vn, 2);
    chk("it3_iter", iter_count, 2);
    chk("it3_converged", converged, 1);
    repeat (2) @(negedge clk);

    // only the last row's parity set in iteration 0
    run_dec(3, -1, dc, vn, pc, cf, cc);
    chk("late_done_cyc", dc, 19);
    chk("late_vn_phases", vn, 1);
    chk("late_iter", iter_count, 1);
    repeat (2) @(negedge clk);

    // start while busy is ignored
    run_dec(0, 3, dc, vn, pc, cf, cc);
    chk("poke_done_cyc", dc, 7);
    repeat (2) @(negedge clk);

    // abort in VN phase at cycle 9
    pmode = 1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_pe_before", pe_en, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_pe", pe_en, 0);
    chk("abort_done", done, 0);
    chk("abort_conv", converged, 0);
    repeat (3) @(negedge clk);
    run_dec(0, -1, dc, vn, pc, cf, cc);
    chk("restart_done_cyc", dc, 7);
    chk("restart_iter", iter_count, 0);
    repeat (2) @(negedge clk);

    // reset during CN phase
    pmode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_busy", busy, 0);
    chk("mrst_cnu", cnu_en, 0);
    chk("mrst_row", row_addr, 0);
    chk("mrst_conv", converged, 0);

    // start and abort together in idle
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_cnu", cnu_en, 0);

    // random traffic
    pmode = 4;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 500 == 0) begin
        case ($urandom_range(0, 3))
          0: pth = 0;
          1: pth = 10;
          2: pth = 50;
          default: pth = 100;
        endcase
      end
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 79) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
